// File: rtl/varlat_bank_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// varlat_bank_arbiter: round-robin N:1 bank arbiter with in-order routing of
// variable-latency responses. Optional counters: VARLAT_BANK_ARB_PERF_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module varlat_bank_arbiter #(
  parameter int NumIn          = 4,
  parameter int AddrMemWidth   = 12,
  parameter int DataWidth      = 32,
  parameter int BeWidth        = DataWidth / 8,
  parameter int NumOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumIn-1:0]                     req_i,
  output logic [NumIn-1:0]                     gnt_o,
  input  logic [NumIn-1:0][AddrMemWidth-1:0]   add_i,
  input  logic [NumIn-1:0]                     we_i,
  input  logic [NumIn-1:0][DataWidth-1:0]      wdata_i,
  input  logic [NumIn-1:0][BeWidth-1:0]        be_i,
  output logic [NumIn-1:0]                     vld_o,
  output logic [NumIn-1:0][DataWidth-1:0]      rdata_o,
  output logic                                 req_o,
  input  logic                                 gnt_i,
  output logic [AddrMemWidth-1:0]              add_o,
  output logic                                 we_o,
  output logic [DataWidth-1:0]                 wdata_o,
  output logic [BeWidth-1:0]                   be_o,
  input  logic                                 rvalid_i,
  output logic                                 rready_o,
  input  logic [DataWidth-1:0]                 rdata_i,
  output logic [31:0]                          busy_cnt_o,
  output logic [31:0]                          conflict_cnt_o
);

  localparam int c_IDX_W = $clog2(NumIn);
  localparam int c_PTR_W = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int c_CNT_W = $clog2(NumOutstanding + 1);
  localparam logic [c_IDX_W:0]   c_NUM_IN   = (c_IDX_W + 1)'(NumIn);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NumIn - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(NumOutstanding - 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(NumOutstanding);

  logic [c_IDX_W-1:0] r_rr_ptr;
  logic [c_IDX_W-1:0] r_fifo [NumOutstanding];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;

  logic [c_IDX_W:0]   w_idx;
  logic [c_IDX_W-1:0] w_win;
  logic [c_IDX_W-1:0] w_head;
  logic               w_any;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  // Scan requesters starting at r_rr_ptr; the first hit is the winner.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NumIn; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (c_IDX_W + 1)'(k);
      if (w_idx >= c_NUM_IN) w_idx = w_idx - c_NUM_IN;
      if (!w_any && req_i[w_idx[c_IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[c_IDX_W-1:0];
      end
    end
  end

  assign w_full   = (r_count == c_DEPTH);
  assign req_o    = w_any & ~w_full & ~rst_i;
  assign w_push   = req_o & gnt_i;
  assign rready_o = (r_count != '0);
  assign w_pop    = rvalid_i & rready_o;
  assign w_head   = r_fifo[r_rptr];

  assign add_o   = add_i[w_win];
  assign we_o    = we_i[w_win];
  assign wdata_o = wdata_i[w_win];
  assign be_o    = be_i[w_win];

  always_comb begin
    gnt_o = '0;
    vld_o = '0;
    if (w_push) gnt_o[w_win]  = 1'b1;
    if (w_pop)  vld_o[w_head] = 1'b1;
  end

  for (genvar gi = 0; gi < NumIn; gi++) begin : g_rdata
    assign rdata_o[gi] = rdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_rr_ptr <= (w_win == c_IDX_LAST) ? '0 : w_win + c_IDX_W'(1);
        r_wptr   <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + c_PTR_W'(1);
      end
      if (w_pop) r_rptr <= (r_rptr == c_PTR_LAST) ? '0 : r_rptr + c_PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - c_CNT_W'(1);
    end
  end

  // ID storage needs no reset: occupancy is tracked by r_count alone.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= w_win;
  end

`ifdef VARLAT_BANK_ARB_PERF_EN
  logic [31:0] r_busy_cnt;
  logic [31:0] r_conflict_cnt;
  logic        w_multi;
  logic        w_conflict;

  assign w_multi    = |(req_i & (req_i - NumIn'(1)));
  assign w_conflict = w_multi | (w_any & ~w_push);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy_cnt     <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_push)     r_busy_cnt     <= r_busy_cnt + 32'd1;
      if (w_conflict) r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign busy_cnt_o     = r_busy_cnt;
  assign conflict_cnt_o = r_conflict_cnt;
`else
  assign busy_cnt_o     = '0;
  assign conflict_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_varlat_bank_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_varlat_bank_arbiter: scoreboard bench for varlat_bank_arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_varlat_bank_arbiter;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int NO = 2;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic [N-1:0]           req_i, gnt_o, we_i, vld_o;
  logic [N-1:0][AW-1:0]   add_i;
  logic [N-1:0][DW-1:0]   wdata_i, rdata_o;
  logic [N-1:0][BW-1:0]   be_i;
  logic                   req_o, gnt_i, we_o, rvalid_i, rready_o;
  logic [AW-1:0]          add_o;
  logic [DW-1:0]          wdata_o, rdata_i;
  logic [BW-1:0]          be_o;
  logic [31:0]            busy_cnt_o, conflict_cnt_o;

  varlat_bank_arbiter #(
    .NumIn(N), .AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW), .NumOutstanding(NO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i),
    .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i), .vld_o(vld_o), .rdata_o(rdata_o),
    .req_o(req_o), .gnt_i(gnt_i), .add_o(add_o), .we_o(we_o), .wdata_o(wdata_o),
    .be_o(be_o), .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
    .busy_cnt_o(busy_cnt_o), .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_q[$];
  int          m_rr = 0;
  logic [31:0] m_busy = '0;
  logic [31:0] m_conf = '0;
  logic [N-1:0]  last_gnt, last_vld;
  logic [DW-1:0] last_rdata;
  logic [31:0]   last_busy, last_conf;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int model_win(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // One clock: drive, compare against the model at negedge, advance the model.
  task automatic cycle(input logic [N-1:0] req, input logic g, input logic rv,
                       input logic [DW-1:0] rd);
    logic         exp_req, push, pop, conf;
    int           w;
    logic [N-1:0] exp_gnt, exp_vld;
    req_i = req; gnt_i = g; rvalid_i = rv; rdata_i = rd;
    @(negedge clk);
    exp_req = (|req) && (exp_q.size() < NO);
    w       = model_win(req, m_rr);
    push    = exp_req && g;
    pop     = rv && (exp_q.size() != 0);
    exp_gnt = push ? (4'b0001 << w) : 4'b0000;
    exp_vld = pop ? (4'b0001 << exp_q[0]) : 4'b0000;
    check("req_o", req_o, exp_req);
    check("gnt_o", gnt_o, exp_gnt);
    check("rready_o", rready_o, exp_q.size() != 0);
    check("vld_o", vld_o, exp_vld);
    if (exp_req) begin
      check("add_o", add_o, add_i[w]);
      check("we_o", we_o, we_i[w]);
      check("wdata_o", wdata_o, wdata_i[w]);
      check("be_o", be_o, be_i[w]);
    end
    if (pop)
      for (int i = 0; i < N; i++) check($sformatf("rdata_o[%0d]", i), rdata_o[i], rd);
`ifdef VARLAT_BANK_ARB_PERF_EN
    check("busy_cnt", busy_cnt_o, m_busy);
    check("conflict_cnt", conflict_cnt_o, m_conf);
`else
    check("busy_cnt", busy_cnt_o, 0);
    check("conflict_cnt", conflict_cnt_o, 0);
`endif
    last_gnt = gnt_o; last_vld = vld_o; last_rdata = rdata_o[0];
    last_busy = busy_cnt_o; last_conf = conflict_cnt_o;
    conf = ($countones(req) > 1) || ((|req) && !push);
    if (conf) m_conf = m_conf + 32'd1;
    if (push) m_busy = m_busy + 32'd1;
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back(w);
      m_rr = (w + 1) % N;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_i = '1; gnt_i = 1'b1; rvalid_i = 1'b1;
    @(negedge clk);
    check("rst_req_o", req_o, 0);
    check("rst_gnt_o", gnt_o, 0);
    check("rst_vld_o", vld_o, 0);
    check("rst_rready_o", rready_o, 0);
    check("rst_busy_cnt", busy_cnt_o, 0);
    check("rst_conflict_cnt", conflict_cnt_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0; req_i = '0; gnt_i = 1'b0; rvalid_i = 1'b0;
    exp_q.delete();
    m_rr = 0; m_busy = '0; m_conf = '0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 8) begin
      cycle('0, 1'b0, 1'b1, DW'($urandom));
      guard++;
    end
    check("drain_empty", rready_o, 0);
  endtask

  logic [N-1:0] seq029 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst_i = 1'b1; req_i = '0; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    we_i = 4'b0101;
    for (int i = 0; i < N; i++) begin
      add_i[i]   = AW'(12'h100 + i);
      wdata_i[i] = DW'(32'hD000_0000 + i);
      be_i[i]    = BW'(4'h1 << i);
    end
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Round-robin rotation with responses one cycle after each grant
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b1, i > 0, DW'(32'h1000 + i));
      check($sformatf("seq029_%0d", i), last_gnt, seq029[i]);
    end
    drain();

    // FIFO-full blocking; freed slot usable only from the next cycle
    for (int i = 0; i < 3; i++) cycle(4'b0001, 1'b1, 1'b0, '0);
    check("full_gnt", last_gnt, 4'b0000);
    cycle(4'b0001, 1'b1, 1'b1, 32'h1111_2222);
    check("full_pop_gnt", last_gnt, 4'b0000);
    check("full_pop_vld", last_vld, 4'b0001);
    cycle(4'b0001, 1'b1, 1'b0, '0);
    check("after_pop_gnt", last_gnt, 4'b0001);
    drain();

    // In-order response routing
    cycle(4'b0100, 1'b1, 1'b0, '0);
    cycle(4'b0001, 1'b1, 1'b0, '0);
    cycle('0, 1'b0, 1'b1, 32'hA5A5_A5A5);
    check("route_vld_a", last_vld, 4'b0100);
    check("route_data_a", last_rdata, 32'hA5A5_A5A5);
    cycle('0, 1'b0, 1'b1, 32'h5A5A_5A5A);
    check("route_vld_b", last_vld, 4'b0001);
    check("route_data_b", last_rdata, 32'h5A5A_5A5A);

    // Stray response with nothing outstanding
    cycle('0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    check("stray_vld", last_vld, 4'b0000);

    // Bank back-pressure holds the pointer
    for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b0, 1'b0, '0);
    cycle(4'b1111, 1'b1, 1'b0, '0);
    drain();

    // Random traffic
    for (int i = 0; i < 300; i++)
      cycle(N'($urandom), 1'($urandom), 1'($urandom), DW'($urandom));
    drain();

    // Reset mid-operation with two outstanding
    cycle(4'b1111, 1'b1, 1'b0, '0);
    cycle(4'b1111, 1'b1, 1'b0, '0);
    do_reset();
    cycle('0, 1'b0, 1'b1, 32'hCAFE_F00D);
    check("post_rst_vld", last_vld, 4'b0000);
    cycle(4'b1010, 1'b1, 1'b0, '0);
    check("post_rst_gnt", last_gnt, 4'b0010);
    drain();

    // Performance counters over ten contended grants
    do_reset();
    for (int i = 0; i < 10; i++) cycle(4'b0011, 1'b1, i > 0, DW'(i));
    cycle('0, 1'b0, 1'b0, '0);
`ifdef VARLAT_BANK_ARB_PERF_EN
    check("perf_busy", last_busy, 10);
    check("perf_conflict", last_conf, 10);
`else
    check("perf_busy", last_busy, 0);
    check("perf_conflict", last_conf, 0);
`endif
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/varlat_bank_arbiter.md
VARLAT_BANK_ARBITER -- requirements
Module: varlat_bank_arbiter

Interface
REQ-001 SHALL have parameter NumIn, default 4: number of requesters sharing one bank (2..32).
REQ-002 SHALL have parameter AddrMemWidth, default 12: bank word-address width.
REQ-003 SHALL have parameter DataWidth, default 32: data width; BeWidth, default DataWidth/8: byte-enable width.
REQ-004 SHALL have parameter NumOutstanding, default 2: maximum number of accepted requests awaiting a response (1..16).
REQ-005 SHALL have ports: clk_i  in  1  the single clock, rising edge.
REQ-006 rst_i  in  1  reset, asynchronous and active-high.
REQ-007 req_i  in  NumIn  request per requester; gnt_o  out  NumIn  grant per requester.
REQ-008 add_i  in  NumIn x AddrMemWidth; we_i  in  NumIn; wdata_i  in  NumIn x DataWidth; be_i  in  NumIn x BeWidth.
REQ-009 vld_o  out  NumIn  response valid; rdata_o  out  NumIn x DataWidth  response data.
REQ-010 req_o  out  1; gnt_i  in  1; add_o  out  AddrMemWidth; we_o  out  1; wdata_o  out  DataWidth; be_o  out  BeWidth: bank request side.
REQ-011 rvalid_i  in  1; rready_o  out  1; rdata_i  in  DataWidth: bank response side.
REQ-012 busy_cnt_o  out  32  granted-request counter; conflict_cnt_o  out  32  conflict-cycle counter.

Function
REQ-013 SHALL arbitrate round-robin: the winner is the lowest index >= rr_ptr with req_i high, wrapping to index 0 and up.
REQ-014 SHALL drive req_o = (any req_i) AND NOT id_fifo_full; add_o/we_o/wdata_o/be_o = winner's fields; outputs are don't-care when req_o is 0.
REQ-015 SHALL assert gnt_o[w] = req_o AND gnt_i for the winner w only, in the same cycle; all other gnt_o bits stay 0.
REQ-016 SHALL treat a handshake (req_o AND gnt_i) as acceptance: push w into the ID FIFO (depth NumOutstanding, no fall-through) and set rr_ptr = (w+1) mod NumIn at the next edge.
REQ-017 SHALL hold rr_ptr when no handshake occurs.
REQ-018 SHALL drive rready_o = NOT id_fifo_empty.
REQ-019 SHALL, on rvalid_i AND rready_o, assert vld_o[head] for one cycle, drive rdata_o[i] = rdata_i for all i, and pop the FIFO.
REQ-020 SHALL require a minimum response latency of one cycle: a request accepted in cycle t is returnable no earlier than t+1.
REQ-021 SHALL deliver responses in acceptance order; every accepted request, read or write, receives exactly one response.
REQ-022 SHALL block when the FIFO is full (gnt_o all 0, req_o 0), even if a pop occurs in the same cycle; the freed slot is usable from the next cycle.
REQ-023 SHALL ignore rvalid_i while the FIFO is empty (rready_o 0, no vld_o).
REQ-024 SHALL, on simultaneous push and pop with FIFO non-full, perform both; occupancy is unchanged.

Reset
REQ-025 SHALL, while rst_i is high, clear rr_ptr to 0 and empty the FIFO; gnt_o, vld_o, req_o, rready_o read 0; counters read 0.
REQ-026 SHALL, on reset mid-operation, discard outstanding IDs; bank responses arriving after release with FIFO empty are ignored (REQ-023).

Configuration
REQ-027 SHALL, with VARLAT_BANK_ARB_PERF_EN defined, increment busy_cnt_o on every handshake and conflict_cnt_o on every cycle where more than one req_i is high or a req_i is high but no handshake occurs; both counters wrap at 2^32.
REQ-028 SHALL, without VARLAT_BANK_ARB_PERF_EN, tie busy_cnt_o and conflict_cnt_o to 0 and instantiate no counter flops.

Verification
REQ-029 Scenario: NumIn=4; req_i=4'b1111 held, gnt_i=1, rvalid_i=1 one cycle after each grant. Required: gnt_o sequence 0001, 0010, 0100, 1000, 0001.
REQ-030 Scenario: NumOutstanding=2, gnt_i=1, rvalid_i=0, req_i[0] held. Required: two grants, then gnt_o=0 and req_o=0; after one rvalid_i pulse, a grant in the following cycle, not the same cycle.
REQ-031 Scenario: grants to requesters 2 then 0; rdata_i=0xA5A5A5A5 then 0x5A5A5A5A. Required: vld_o=4'b0100 with 0xA5A5A5A5, then vld_o=4'b0001 with 0x5A5A5A5A.
REQ-032 Scenario: rvalid_i=1 with FIFO empty. Required: rready_o=0 and vld_o=0.
REQ-033 Scenario: rst_i pulsed with 2 outstanding. Required: rr_ptr=0, rready_o=0, counters=0; a subsequent req_i=4'b1010 is granted to requester 1.
REQ-034 Scenario: with VARLAT_BANK_ARB_PERF_EN, 10 cycles with req_i=4'b0011 and gnt_i=1. Required: busy_cnt_o=10, conflict_cnt_o=10; without the macro, both read 0.
